// File: rtl/led_seq_driver.sv
// LED sequence driver: steps a 2-bit LED code through a fixed 4-entry table,
// holding each entry for DWELL cycles, with pause/abort and optional looping.
module led_seq_driver #(
  parameter int DWELL = 100,
  parameter int LOOP  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  output logic [1:0] dataIn,
  output logic       ledOn,
  output logic [1:0] step,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(DWELL - 1);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [1:0]  step_reg, step_next;
  logic [1:0]  data_reg, data_next;
  logic        led_reg, led_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 16'd0;
      step_reg  <= 2'd0;
      data_reg  <= 2'b00;
      led_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      step_reg  <= step_next;
      data_reg  <= data_next;
      led_reg   <= led_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Leaving PAUSE with pause low counts as a counting cycle, the same as RUN.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    step_next  = step_reg;
    done_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          state_next = RUN;
          cnt_next   = 16'd0;
          step_next  = 2'd0;
        end
      end
      RUN, PAUSE: begin
        if (abort) begin
          state_next = IDLE;
          cnt_next   = 16'd0;
          step_next  = 2'd0;
        end else if (pause) begin
          state_next = PAUSE;
        end else begin
          state_next = RUN;
          if (cnt_reg == LAST_CNT) begin
            cnt_next = 16'd0;
            if (step_reg == 2'd3 && LOOP == 0) begin
              state_next = IDLE;
              step_next  = 2'd0;
              done_next  = 1'b1;
            end else begin
              step_next = step_reg + 2'd1;
            end
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 16'd0;
        step_next  = 2'd0;
      end
    endcase
  end

  // Outputs are registered from the next-state view so they change with the step.
  always_comb begin
    data_next = 2'b00;
    led_next  = 1'b0;
    busy_next = (state_next != IDLE);
    if (state_next != IDLE) begin
      unique case (step_next)
        2'd0: begin data_next = 2'b00; led_next = 1'b0; end
        2'd1: begin data_next = 2'b01; led_next = 1'b1; end
        2'd2: begin data_next = 2'b10; led_next = 1'b1; end
        default: begin data_next = 2'b00; led_next = 1'b1; end
      endcase
    end
  end

  assign dataIn = data_reg;
  assign ledOn  = led_reg;
  assign step   = step_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_led_seq_driver.sv
// Bench for led_seq_driver: single-pass and looping instances share stimulus and
// are compared every cycle against a progress-count reference model.
module tb_led_seq_driver;
  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] data0, step0, data1, step1;
  logic       led0, busy0, done0, led1, busy1, done1;
  logic [6:0] obs0, obs1;

  int checks = 0;
  int errors = 0;

  // Reference model: progress = counting edges since start; step = progress / DWELL.
  bit m_act[2];
  int m_prog[2];
  bit m_done[2];

  always #5 clk = ~clk;

  led_seq_driver #(.DWELL(DWELL), .LOOP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
    .dataIn(data0), .ledOn(led0), .step(step0), .busy(busy0), .done(done0)
  );

  led_seq_driver #(.DWELL(DWELL), .LOOP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
    .dataIn(data1), .ledOn(led1), .step(step1), .busy(busy1), .done(done1)
  );

  assign obs0 = {data0, led0, step0, busy0, done0};
  assign obs1 = {data1, led1, step1, busy1, done1};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0; m_prog[i] = 0; m_done[i] = 1'b0;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (!m_act[i]) begin
        if (start && !abort) begin
          m_act[i] = 1'b1; m_prog[i] = 0;
        end
      end else if (abort) begin
        m_act[i] = 1'b0;
      end else if (!pause) begin
        m_prog[i]++;
        if (m_prog[i] == 4 * DWELL) begin
          if (i == 1) m_prog[i] = 0;
          else begin m_act[i] = 1'b0; m_done[i] = 1'b1; end
        end
      end
    end
  endtask

  // Packed {dataIn, ledOn, step, busy, done}
  function automatic logic [6:0] exp_vec(input int i);
    logic [1:0] s;
    logic [2:0] tbl;
    if (!m_act[i]) return {6'b0, m_done[i]};
    s = 2'(m_prog[i] / DWELL);
    case (s)
      2'd0: tbl = 3'b000;
      2'd1: tbl = 3'b011;
      2'd2: tbl = 3'b101;
      default: tbl = 3'b001;
    endcase
    return {tbl, s, 1'b1, 1'b0};
  endfunction

  task automatic compare_all(input string tag);
    check_val({tag, "/loop0"}, 32'(obs0), 32'(exp_vec(0)));
    check_val({tag, "/loop1"}, 32'(obs1), 32'(exp_vec(1)));
  endtask

  // One clock: model follows the edge, outputs are sampled on the falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_update();
    @(negedge clk);
    compare_all(tag);
  endtask

  // kind: 0 plain pass, 1 pause in cycles 6-8, 2 abort at cycle 10, 3 extra start at cycle 6
  task automatic scenario(input int kind);
    start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick("seq");
      if (kind == 0 || kind == 3) begin
        if (c == 1)  begin check_val("c1_busy", busy0, 1); check_val("c1_out", {data0, led0}, 3'b000); end
        if (c == 5)  check_val("c5_out", {data0, led0}, 3'b011);
        if (c == 9)  check_val("c9_out", {data0, led0}, 3'b101);
        if (c == 13) check_val("c13_out", {data0, led0}, 3'b001);
        if (c == 17) begin
          check_val("c17_busy", busy0, 0); check_val("c17_done", done0, 1);
          check_val("c17_out", {data0, led0}, 3'b000);
          check_val("loop_wrap_step", step1, 0); check_val("loop_wrap_out", {data1, led1}, 3'b000);
          check_val("loop_wrap_busy", busy1, 1);
        end
        if (c == 18) check_val("c18_done", done0, 0);
      end
      if (kind == 1) begin
        if (c >= 7 && c <= 11) check_val("pause_hold", {data0, led0, step0}, 5'b01101);
        if (c == 12) check_val("pause_step2", step0, 2);
      end
      if (kind == 2 && c == 11) begin
        check_val("abort_busy", busy0, 0); check_val("abort_out", {data0, led0}, 3'b000);
        check_val("abort_done", done0, 0); check_val("abort_busy_loop", busy1, 0);
      end
      check_val("loop_no_done", done1, 0);
      start = (kind == 3 && c == 6);
      pause = (kind == 1 && c >= 6 && c <= 8);
      abort = (kind == 2 && c == 10);
    end
    abort = 1'b1;
    tick("flush");
    abort = 1'b0;
    tick("flush");
  endtask

  task automatic async_pulse();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_val("arst_busy", busy0, 0);
    check_val("arst_out", {data0, led0, step0}, 5'b0);
    compare_all("arst");
    tick("arst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all("reset");
    check_val("reset_busy", busy0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("idle");

    for (int k = 0; k < 4; k++) begin
      scenario(k);
      $display("scenario %0d complete: checks=%0d errors=%0d", k, checks, errors);
    end

    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick("pre_arst");
      start = 1'b0;
    end
    async_pulse();
    for (int c = 0; c < 10; c++) begin
      tick("post_arst");
      check_val("post_arst_done", done0, 0);
      check_val("post_arst_idle", busy0, 0);
    end
    $display("async reset scenario complete: checks=%0d errors=%0d", checks, errors);

    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 15) == 0);
      abort = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      if ($urandom_range(0, 499) == 0) async_pulse();
      else tick("rand");
    end
    $display("random phase complete: checks=%0d errors=%0d", checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_seq_driver.md
LED_SEQ_DRIVER -- requirements
Module: led_seq_driver

Parameters
REQ-001 The block SHALL have parameter DWELL, default 100: clock cycles spent in each sequence step; legal range 2..65535.
REQ-002 The block SHALL have parameter LOOP, default 0: 0 = run a single pass and stop; 1 = repeat the sequence until aborted.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle request to begin a sequence.
REQ-006 The block SHALL have port pause, input, 1 bit: level; while high, a running sequence freezes.
REQ-007 The block SHALL have port abort, input, 1 bit: single-cycle request to terminate immediately.
REQ-008 The block SHALL have port dataIn, output, 2 bits: LED data code, driven to the LED block's dataIn.
REQ-009 The block SHALL have port ledOn, output, 1 bit: LED enable, driven to the LED block's ledOn.
REQ-010 The block SHALL have port step, output, 2 bits: current sequence step index.
REQ-011 The block SHALL have port busy, output, 1 bit: high in RUN or PAUSE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse on normal completion of a pass (LOOP=0 only).
REQ-013 The block SHALL drive all outputs directly from registers, with no combinational path from any input to any output.

Function
REQ-014 The block SHALL implement exactly three states: IDLE, RUN and PAUSE.
REQ-015 The block SHALL use this fixed step table (step: dataIn, ledOn): 0: 00,0; 1: 01,1; 2: 10,1; 3: 00,1.
REQ-016 In IDLE, the block SHALL drive dataIn=00, ledOn=0, step=0, busy=0.
REQ-017 In IDLE with start=1 and abort=0, the block SHALL, in the next cycle, enter RUN with step=0, dwell counter=0, outputs set to table[0] and busy=1.
REQ-018 In RUN, the 16-bit dwell counter SHALL increment by one each cycle while pause=0.
REQ-019 In RUN, when counter==DWELL-1, the block SHALL clear the counter and advance step by one in the next cycle, with outputs updated in that same cycle.
REQ-020 At the end of step 3 with LOOP=0, the block SHALL in the next cycle enter IDLE with idle outputs and done=1 for exactly that one cycle.
REQ-021 At the end of step 3 with LOOP=1, step SHALL wrap to 0 and the block SHALL stay in RUN, with done never asserted.
REQ-022 In RUN with pause=1, the block SHALL enter PAUSE in the next cycle and perform no counter increment and no step advance in that cycle.
REQ-023 In PAUSE, the counter, step and dataIn/ledOn SHALL hold their values.
REQ-024 In PAUSE, pause=0 SHALL return the block to RUN in the next cycle, with counting resuming from the held value.
REQ-025 abort=1 in RUN or PAUSE SHALL force IDLE with idle outputs in the next cycle, with done=0; abort takes priority over pause and over step advance.
REQ-026 start SHALL be ignored while busy=1, with no restart and no counter clear.
REQ-027 start and abort asserted together in IDLE SHALL leave the block in IDLE.
REQ-028 pause SHALL be ignored in IDLE; it is sampled only from the first RUN cycle onward.
REQ-029 Each step SHALL last exactly DWELL cycles of non-paused RUN, so one pass equals 4*DWELL RUN cycles.

Reset
REQ-030 While rst_n=0, the block SHALL immediately, without waiting for clk, force: state=IDLE, counter=0, step=0, dataIn=00, ledOn=0, busy=0, done=0.
REQ-031 Reset mid-sequence (RUN or PAUSE) SHALL abandon the sequence with no done pulse.
REQ-032 After rst_n deassertion, the block SHALL require a new start pulse before leaving IDLE.

Verification (DWELL=4, start pulse at cycle 0 unless stated)
REQ-033 Single pass, LOOP=0: the bench SHALL confirm busy=1 and dataIn/ledOn=00/0 at cycle 1, 01/1 at cycle 5, 10/1 at cycle 9, 00/1 at cycle 13, then busy=0, done=1 and 00/0 at cycle 17, and done=0 at cycle 18.
REQ-034 Pause: with pause high during cycles 6-8, the bench SHALL confirm step 2 is delayed to cycle 12 and outputs hold 01/1 during the pause.
REQ-035 Abort: with abort at cycle 10, the bench SHALL confirm IDLE, 00/0, busy=0 and done=0 at cycle 11.
REQ-036 LOOP=1: the bench SHALL confirm step wraps 3->0 at cycle 17 with 00/0 and busy=1, and done is never asserted.
REQ-037 Ignored start: with a second start at cycle 6, the bench SHALL confirm the timing of REQ-033 is unchanged.
REQ-038 Async reset: with rst_n low at cycle 7 between clock edges, the bench SHALL confirm outputs go to 00/0 and busy=0 before the next edge, and no done pulse follows.
